// File: rtl/xadc_ascii_pkg.sv
// xadc_ascii_pkg: shared FSM encoding, ASCII constants and digit formatting.
// Define XADC_ASCII_BLANK_EN to render leading zero digits as spaces.
package xadc_ascii_pkg;
  typedef enum logic [1:0] {IDLE, SCALE, CONVERT, WRITE} state_t;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int BCD_DIGITS = 4;
  localparam int CONV_CYCLES = 14;
`ifdef XADC_ASCII_BLANK_EN
  localparam logic [31:0] DOUT_RST = 32'h20202030;
`else
  localparam logic [31:0] DOUT_RST = 32'h30303030;
`endif
  function automatic logic [31:0] bcd2ascii(input logic [15:0] bcd);
    logic [31:0] a;
`ifdef XADC_ASCII_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    a = '0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      a[8*i+:8] = ASCII_ZERO + {4'h0, bcd[4*i+:4]};
`ifdef XADC_ASCII_BLANK_EN
      // the units digit is never blanked, so a zero reading still shows "0"
      if (lead && i > 0 && bcd[4*i+:4] == 4'h0) a[8*i+:8] = ASCII_SPACE;
      else lead = 1'b0;
`endif
    end
    return a;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, MSB first.
import xadc_ascii_pkg::*;
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [13:0] i_bin,
  output logic        o_done,
  output logic [15:0] o_bcd
);
  logic [13:0] r_sh;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [15:0] w_adj;
  logic [29:0] w_shift;
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    assign w_adj[4*d+:4] = r_bcd[4*d+:4] >= 4'd5 ? r_bcd[4*d+:4] + 4'd3 : r_bcd[4*d+:4];
  end
  assign w_shift = {w_adj, r_sh} << 1;
  // o_done marks the cycle whose closing edge performs the final shift
  assign o_done = r_busy && r_cnt == 4'd1;
  assign o_bcd = r_bcd;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_sh <= i_bin;
      r_bcd <= '0;
      r_cnt <= 4'(CONV_CYCLES);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= w_shift[29:14];
      r_sh <= w_shift[13:0];
      r_cnt <= r_cnt - 4'd1;
      r_busy <= r_cnt != 4'd1;
    end
  end
endmodule

// File: rtl/xadc_ascii_fmt.sv
// xadc_ascii_fmt: scales XADC codes to millivolts and writes 4-char ASCII per channel.
// Define XADC_ASCII_BLANK_EN to blank leading zeros.
import xadc_ascii_pkg::*;
module xadc_ascii_fmt #(
  parameter int FULL_SCALE_MV = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic        sample_valid,
  input  logic [1:0]  sample_ch,
  input  logic [11:0] sample_data,
  output logic        sample_ready,
  output logic [31:0] dout0,
  output logic [31:0] dout1,
  output logic [31:0] dout2,
  output logic [31:0] dout3,
  output logic        update
);
  state_t      r_state, w_next;
  logic [1:0]  r_ch;
  logic [11:0] r_data;
  logic [31:0] r_dout [4];
  logic        r_update;
  logic [25:0] w_prod;
  logic [13:0] w_mv;
  logic        w_done;
  logic [15:0] w_bcd;
  assign w_prod = 26'(r_data) * 26'(FULL_SCALE_MV);
  assign w_mv = 14'(w_prod >> 12);
  bin2bcd_seq u_bcd (
    .clk    (CLK100MHZ),
    .rst    (RST),
    .i_start(r_state == SCALE),
    .i_bin  (w_mv),
    .o_done (w_done),
    .o_bcd  (w_bcd)
  );
  always_comb begin
    w_next = r_state == IDLE    ? (sample_valid ? SCALE : IDLE) :
             r_state == SCALE   ? CONVERT :
             r_state == CONVERT ? (w_done ? WRITE : CONVERT) : IDLE;
    sample_ready = r_state == IDLE;
  end
  always_ff @(posedge CLK100MHZ) begin
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_ch <= '0;
      r_data <= '0;
      r_update <= 1'b0;
      for (int i = 0; i < 4; i++) r_dout[i] <= DOUT_RST;
    end else begin
      r_update <= r_state == WRITE;
      if (sample_valid && sample_ready) begin
        r_ch <= sample_ch;
        r_data <= sample_data;
      end
      if (r_state == WRITE) r_dout[r_ch] <= bcd2ascii(w_bcd);
    end
  end
  assign dout0 = r_dout[0];
  assign dout1 = r_dout[1];
  assign dout2 = r_dout[2];
  assign dout3 = r_dout[3];
  assign update = r_update;
endmodule

// File: tb/tb_xadc_ascii_fmt.sv
// tb_xadc_ascii_fmt: directed and random checks against an arithmetic reference model.
module tb_xadc_ascii_fmt;
  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        sample_valid = 1'b0;
  logic [1:0]  sample_ch = '0;
  logic [11:0] sample_data = '0;
  logic        rdy_a, rdy_b, upd_a, upd_b;
  logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [31:0] exp_a [4];
  logic [31:0] exp_b [4];
  logic [31:0] rst_val;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  xadc_ascii_fmt #(.FULL_SCALE_MV(1000)) dut_a (
    .CLK100MHZ(clk), .RST(RST), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .sample_ready(rdy_a), .dout0(a0), .dout1(a1),
    .dout2(a2), .dout3(a3), .update(upd_a));
  xadc_ascii_fmt #(.FULL_SCALE_MV(9999)) dut_b (
    .CLK100MHZ(clk), .RST(RST), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .sample_ready(rdy_b), .dout0(b0), .dout1(b1),
    .dout2(b2), .dout3(b3), .update(upd_b));
  function automatic logic [31:0] model(input int fs, input int d);
    int mv = (d * fs) / 4096;
    int dg [4];
    logic [31:0] r;
    dg[3] = mv / 1000;
    dg[2] = (mv / 100) % 10;
    dg[1] = (mv / 10) % 10;
    dg[0] = mv % 10;
    for (int i = 0; i < 4; i++) r[8*i+:8] = 8'(48 + dg[i]);
`ifdef XADC_ASCII_BLANK_EN
    if (mv < 1000) r[31:24] = 8'h20;
    if (mv < 100) r[23:16] = 8'h20;
    if (mv < 10) r[15:8] = 8'h20;
`endif
    return r;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic check_douts(input string tag);
    check({tag, "_a0"}, a0, exp_a[0]);
    check({tag, "_a1"}, a1, exp_a[1]);
    check({tag, "_a2"}, a2, exp_a[2]);
    check({tag, "_a3"}, a3, exp_a[3]);
    check({tag, "_b0"}, b0, exp_b[0]);
    check({tag, "_b1"}, b1, exp_b[1]);
    check({tag, "_b2"}, b2, exp_b[2]);
    check({tag, "_b3"}, b3, exp_b[3]);
  endtask
  task automatic accept(input logic [1:0] ch, input logic [11:0] d);
    int t = 0;
    @(negedge clk);
    while (!rdy_a && t < 100) begin @(negedge clk); t++; end
    check("ready_before_accept", {31'b0, rdy_a & rdy_b}, 32'd1);
    sample_valid = 1'b1;
    sample_ch = ch;
    sample_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic finish_txn(input logic [1:0] ch, input logic [11:0] d, input string tag);
    int k = 0;
    int busy_bad = 0;
    int early_upd = 0;
    while (!upd_a && k < 40) begin
      if (rdy_a || rdy_b) busy_bad++;
      if (upd_b) early_upd++;
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_latency"}, k, 16);
    check({tag, "_busy_ready"}, busy_bad, 0);
    check({tag, "_upd_b"}, {31'b0, upd_b}, 32'd1);
    check({tag, "_early_upd"}, early_upd, 0);
    exp_a[ch] = model(1000, int'(d));
    exp_b[ch] = model(9999, int'(d));
    check_douts(tag);
    @(posedge clk);
    #1;
    check({tag, "_upd_one_cycle"}, {30'b0, upd_a, upd_b}, 32'd0);
  endtask
  task automatic txn(input logic [1:0] ch, input logic [11:0] d, input string tag);
    accept(ch, d);
    sample_valid = 1'b0;
    sample_ch = $urandom_range(0, 3);
    sample_data = 12'($urandom);
    finish_txn(ch, d, tag);
  endtask
  initial begin
`ifdef XADC_ASCII_BLANK_EN
    rst_val = 32'h20202030;
`else
    rst_val = 32'h30303030;
`endif
    for (int i = 0; i < 4; i++) begin exp_a[i] = rst_val; exp_b[i] = rst_val; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {30'b0, rdy_a, rdy_b}, 32'd3);
    check("rst_update", {30'b0, upd_a, upd_b}, 32'd0);
    check_douts("rst");
    @(negedge clk);
    RST = 1'b0;
    txn(2'd0, 12'hFFF, "full_scale");
    check("full_scale_literal", a0, model(1000, 4095));
    check("fs9999_literal", b0, 32'h39393936);
    txn(2'd2, 12'h800, "half");
    txn(2'd3, 12'h000, "zero");
    txn(2'd1, 12'h001, "one_lsb");
    txn(2'd1, 12'h029, "small");
    accept(2'd1, 12'h400);
    sample_ch = 2'd0;
    sample_data = 12'hFFF;
    finish_txn(2'd1, 12'h400, "held_first");
    check("held_accepted", {31'b0, rdy_a}, 32'd0);
    sample_valid = 1'b0;
    finish_txn(2'd0, 12'hFFF, "held_second");
    for (int n = 0; n < 24; n++) txn(2'($urandom_range(0, 3)), 12'($urandom), "rand");
    accept(2'($urandom_range(0, 3)), 12'($urandom_range(1, 4095)));
    sample_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    RST = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_update", {30'b0, upd_a, upd_b}, 32'd0);
    @(negedge clk);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin exp_a[i] = rst_val; exp_b[i] = rst_val; end
    begin
      int seen = 0;
      for (int c = 0; c < 24; c++) begin
        @(posedge clk);
        #1;
        if (upd_a || upd_b) seen++;
      end
      check("midrst_no_update", seen, 0);
    end
    check("midrst_ready", {30'b0, rdy_a, rdy_b}, 32'd3);
    check_douts("midrst");
    txn(2'd3, 12'hC35, "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
